// File: rtl/frac_clk_div_m_n.sv
// Fractional M/N clock divider: a frame of M_N source cycles holds short (div_e)
// periods followed by long (div_o) periods; clk_out is a registered, glitch-free flop.
module frac_clk_div_m_n #(
  parameter logic [7:0] M_N   = 8'd87,
  parameter logic [7:0] c89   = 8'd24,
  parameter logic [4:0] div_e = 5'd8,
  parameter logic [4:0] div_o = 5'd9
) (
  input  logic clk_in,
  input  logic rst_n,
  output logic clk_out
);

  localparam int MN_I = int'(M_N);
  localparam int C_I  = int'(c89);
  localparam int DE_I = int'(div_e);
  localparam int DO_I = int'(div_o);

  localparam bit PARAMS_OK =
    (DE_I >= 2) && (DO_I >= 2) && (C_I > 0) && (C_I < MN_I) &&
    ((DE_I >= 2) ? ((C_I % DE_I) == 0) : 1'b0) &&
    ((DO_I >= 2) ? (((MN_I - C_I) % DO_I) == 0) : 1'b0);

  if (!PARAMS_OK) begin : g_bad_params
    $error("frac_clk_div_m_n: illegal parameter set (c89/div_e/div_o must tile M_N exactly)");
  end

  logic [7:0] ccnt_q, ccnt_d;
  logic [4:0] pcnt_q, pcnt_d;
  logic       clk_out_q, clk_out_d;

  logic [7:0] per_len;
  logic [7:0] half_len;
  logic       frame_last;
  logic       per_last;

  // Period type follows the frame position; c89 is a multiple of div_e, so the
  // switch always lands on a period boundary and no period is truncated.
  always_comb begin
    per_len    = (ccnt_q < c89) ? {3'b000, div_e} : {3'b000, div_o};
    half_len   = per_len >> 1;
    frame_last = (ccnt_q == (M_N - 8'd1));
    per_last   = ({3'b000, pcnt_q} == (per_len - 8'd1));
  end

  always_comb begin
    ccnt_d    = frame_last ? 8'd0 : (ccnt_q + 8'd1);
    pcnt_d    = (per_last || frame_last) ? 5'd0 : (pcnt_q + 5'd1);
    clk_out_d = ({3'b000, pcnt_q} < half_len);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      ccnt_q    <= 8'd0;
      pcnt_q    <= 5'd0;
      clk_out_q <= 1'b0;
    end else begin
      ccnt_q    <= ccnt_d;
      pcnt_q    <= pcnt_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out = clk_out_q;

endmodule

// File: tb/tb_frac_clk_div_m_n.sv
// Scoreboard bench for frac_clk_div_m_n: default instance (87 = 3x8 + 7x9) and a
// small override instance (7 = 1x4 + 1x3) run side by side from one clock and reset.
module tb_frac_clk_div_m_n;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  logic clk_out0, clk_out1;

  int checks   = 0;
  int failures = 0;

  int mn [2] = '{87, 7};
  int cs [2] = '{24, 4};
  int de [2] = '{8, 4};
  int dov[2] = '{9, 3};

  logic [1:0] sbq[$];
  int   pos[2];
  int   nrise[2];
  int   last_rise[2];
  logic prev[2];
  int   cyc = 0;
  int   rises_win = 0;

  always #5 clk_in = ~clk_in;

  frac_clk_div_m_n u_dut0 (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .clk_out(clk_out0)
  );

  frac_clk_div_m_n #(
    .M_N  (8'd7),
    .c89  (8'd4),
    .div_e(5'd4),
    .div_o(5'd3)
  ) u_dut1 (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .clk_out(clk_out1)
  );

  task automatic chk(input string tag, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", tag, act, exp_v, cyc);
    end
  endtask

  // Length of the n-th period of a frame, from the short/long period counts.
  function automatic int per_of(input int d, input int idx);
    int ne;
    int nf;
    ne = cs[d] / de[d];
    nf = ne + (mn[d] - cs[d]) / dov[d];
    return ((idx % nf) < ne) ? de[d] : dov[d];
  endfunction

  // Expected clk_out for frame position p: high for the first half of each period.
  function automatic logic exp_out(input int d, input int p);
    if (p < cs[d]) return ((p % de[d]) < (de[d] / 2));
    return (((p - cs[d]) % dov[d]) < (dov[d] / 2));
  endfunction

  task automatic clear_model();
    sbq.delete();
    for (int d = 0; d < 2; d++) begin
      pos[d]       = 0;
      nrise[d]     = 0;
      last_rise[d] = 0;
      prev[d]      = 1'b0;
    end
  endtask

  task automatic step();
    logic [1:0] e;
    logic [1:0] o;
    @(posedge clk_in);
    if (rst_n) begin
      e = {exp_out(1, pos[1]), exp_out(0, pos[0])};
      sbq.push_back(e);
      for (int d = 0; d < 2; d++) pos[d] = (pos[d] + 1) % mn[d];
    end
    @(negedge clk_in);
    cyc++;
    o = {clk_out1, clk_out0};
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("out0", int'(o[0]), int'(e[0]));
      chk("out1", int'(o[1]), int'(e[1]));
    end else begin
      chk("rst_out0", int'(o[0]), 0);
      chk("rst_out1", int'(o[1]), 0);
    end
    for (int d = 0; d < 2; d++) begin
      if (o[d] && !prev[d]) begin
        if (nrise[d] > 0)
          chk((d == 0) ? "gap0" : "gap1", cyc - last_rise[d], per_of(d, nrise[d] - 1));
        last_rise[d] = cyc;
        nrise[d]++;
        if (d == 0) rises_win++;
      end else if (!o[d] && prev[d]) begin
        chk((d == 0) ? "high0" : "high1", cyc - last_rise[d], per_of(d, nrise[d] - 1) / 2);
      end
      prev[d] = o[d];
    end
  endtask

  initial begin
    clear_model();
    rst_n = 1'b0;
    repeat (10) step();

    rst_n = 1'b1;
    rises_win = 0;
    repeat (870) step();
    chk("rises_870", rises_win, 100);

    // Park inside the first long period of a frame while clk_out0 is high.
    for (int i = 0; i < 200 && pos[0] != 26; i++) step();
    chk("pre_rst_high", int'(clk_out0), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst0", int'(clk_out0), 0);
    chk("async_rst1", int'(clk_out1), 0);
    clear_model();
    repeat (5) step();

    rst_n = 1'b1;
    rises_win = 0;
    repeat (174) step();
    chk("rises_174", rises_win, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
